sram_req_ctrl: RTL

- Request-side controller directly upstream of the 1024x37 single-port SRAM macro.
- Converts a valid/ready request stream (read or write) into the macro's active-low strobe interface.
- Captures the macro's registered read data into a small response FIFO with valid/ready backpressure.
- After reset, zero-fills the whole array, because macro contents power up random.

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_resp_fifo.sv | 59 +++++
 rtl/sram_req_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM request controller and its response FIFO.
package sram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 37;
  localparam int unsigned DEPTH_DEF  = 1024;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic csb;
    logic web;
    logic oeb;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{csb: 1'b1, web: 1'b1, oeb: 1'b1};
  localparam strobe_t STROBE_WR   = '{csb: 1'b0, web: 1'b0, oeb: 1'b1};
  localparam strobe_t STROBE_RD   = '{csb: 1'b0, web: 1'b1, oeb: 1'b0};

endpackage

// File: rtl/sram_resp_fifo.sv
// First-word fall-through synchronous FIFO holding SRAM read responses.
module sram_resp_fifo #(
  parameter  int unsigned DATA_W     = 37,
  parameter  int unsigned RESP_DEPTH = 2,
  localparam int unsigned PTR_W      = $clog2(RESP_DEPTH),
  localparam int unsigned CNT_W      = $clog2(RESP_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [RESP_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    w_full    = (r_count == CNT_W'(RESP_DEPTH));
    w_do_pop  = i_pop && (r_count != '0);
    w_do_push = i_push && (!w_full || w_do_pop);
    o_data    = r_mem[r_rd_ptr];
    o_valid   = (r_count != '0);
    o_count   = r_count;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && w_full && !w_do_pop));

endmodule

// File: rtl/sram_req_ctrl.sv
// Request-side controller for a single-port SRAM macro: zero-fill after reset,
// then valid/ready reads and writes with a credit-limited response FIFO.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned RESP_DEPTH = 2,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned CW    = CNT_W + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_inflight;
  logic [DATA_W-1:0] r_wdata_hold;
  strobe_t           w_strb;
  logic              w_fifo_valid;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_pop;
  logic              w_rd_credit;
  logic              w_acc_wr;
  logic              w_acc_rd;

  always_comb begin
    w_state_nxt = r_state;
    w_strb      = STROBE_IDLE;
    sram_a      = '0;
    sram_i      = r_wdata_hold;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    init_done   = 1'b0;
    w_pop       = 1'b0;
    w_rd_credit = 1'b0;
    w_acc_wr    = 1'b0;
    w_acc_rd    = 1'b0;
    if (reset) begin
      sram_i = '0;
    end else begin
      resp_valid = w_fifo_valid;
      w_pop      = w_fifo_valid & resp_ready;
      case (r_state)
        INIT: begin
          w_strb = STROBE_WR;
          sram_a = r_init_cnt;
          sram_i = '0;
          if (r_init_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = RUN;
        end
        RUN: begin
          init_done   = 1'b1;
          // count + inflight - pop < RESP_DEPTH, rearranged to avoid underflow
          w_rd_credit = ({1'b0, w_fifo_count} + CW'(r_inflight)) < (CW'(RESP_DEPTH) + CW'(w_pop));
          req_ready   = req_write | w_rd_credit;
          w_acc_wr    = req_valid & req_write;
          w_acc_rd    = req_valid & ~req_write & w_rd_credit;
          if (w_acc_wr) begin
            w_strb = STROBE_WR;
            sram_a = req_addr;
            sram_i = req_wdata;
          end else if (w_acc_rd) begin
            w_strb = STROBE_RD;
            sram_a = req_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= INIT_ZERO ? INIT : RUN;
      r_init_cnt   <= '0;
      r_inflight   <= 1'b0;
      r_wdata_hold <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_acc_rd;
      if (r_state == INIT) r_init_cnt <= r_init_cnt + ADDR_W'(1);
      if (w_acc_wr) r_wdata_hold <= req_wdata;
    end
  end

  assign sram_csb = w_strb.csb;
  assign sram_web = w_strb.web;
  assign sram_oeb = w_strb.oeb;

  sram_resp_fifo #(
    .DATA_W     (DATA_W),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (r_inflight),
    .i_data  (sram_o),
    .i_pop   (w_pop),
    .o_data  (resp_rdata),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

endmodule
